// File: rtl/traffic_display_driver.sv
`timescale 1ns/1ps
// Lamp, BCD and multiplexed 7-segment driver for the traffic controller's state/time_left outputs.
// Define TRAFFIC_DISP_CHECK_EN to build in the protocol checker and flashing-yellow fault mode.
module traffic_display_driver #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] state,
    input  logic [5:0] time_left,
    output logic       lamp_red,
    output logic       lamp_yellow,
    output logic       lamp_green,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       fault
);
    localparam int         SCAN_W   = $clog2(SCAN_DIV);
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_fsm_t;

    logic [1:0]        state_q, state_d;
    logic [5:0]        time_q, time_d;
    bcd_fsm_t          fsm_q, fsm_d;
    logic [13:0]       sr_q, sr_d;
    logic [2:0]        iter_q, iter_d;
    logic [5:0]        last_q, last_d;
    logic              first_q, first_d;
    logic [3:0]        tens_q, tens_d;
    logic [3:0]        ones_q, ones_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic              dsel_q, dsel_d;
    logic              lamp_red_q, lamp_red_d;
    logic              lamp_yellow_q, lamp_yellow_d;
    logic              lamp_green_q, lamp_green_d;
    logic [6:0]        seg_q, seg_d;
    logic [1:0]        an_q, an_d;
    logic              fault_nxt;

    function automatic logic [13:0] bcd_step(input logic [13:0] v);
        logic [3:0] t;
        logic [3:0] o;
        t = v[13:10];
        o = v[9:6];
        if (t >= 4'd5) t = t + 4'd3;
        if (o >= 4'd5) o = o + 4'd3;
        return {t[2:0], o, v[5:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

`ifdef TRAFFIC_DISP_CHECK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [1:0]         state_p_q;
    logic [5:0]         time_p_q;
    logic               cap_vld_q, p_vld_q;
    logic               fault_q, fault_d, viol;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;

    always_comb begin
        viol = 1'b0;
        if (state_q == 2'b11) begin
            viol = 1'b1;
        end else if (p_vld_q) begin
            if (state_q != state_p_q) begin
                viol = !((state_p_q == 2'b00 && state_q == 2'b10) ||
                         (state_p_q == 2'b10 && state_q == 2'b01) ||
                         (state_p_q == 2'b01 && state_q == 2'b00));
            end else if (time_p_q != 6'd0 && time_q != time_p_q &&
                         time_q != time_p_q - 6'd1) begin
                viol = 1'b1;
            end
        end
        fault_d     = fault_q | viol;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (fault_q) begin
            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // The first captured sample has no real predecessor, so p_vld_q gates the sequence checks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p_q   <= 2'b00;
            time_p_q    <= 6'd0;
            cap_vld_q   <= 1'b0;
            p_vld_q     <= 1'b0;
            fault_q     <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            state_p_q   <= state_q;
            time_p_q    <= time_q;
            cap_vld_q   <= 1'b1;
            p_vld_q     <= cap_vld_q;
            fault_q     <= fault_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign fault_nxt = fault_d;
    assign fault     = fault_q;
`else
    assign fault_nxt = 1'b0;
    assign fault     = 1'b0;
`endif

    always_comb begin
        state_d    = state;
        time_d     = time_left;
        fsm_d      = fsm_q;
        sr_d       = sr_q;
        iter_d     = iter_q;
        last_d     = last_q;
        first_d    = first_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        scan_cnt_d = scan_cnt_q;
        dsel_d     = dsel_q;

        // Any change of the captured value (re)starts the conversion, so stale results never load.
        case (fsm_q)
            IDLE: begin
                if (first_q || time_q != last_q) begin
                    fsm_d   = SHIFT;
                    sr_d    = {8'd0, time_q};
                    last_d  = time_q;
                    iter_d  = 3'd0;
                    first_d = 1'b0;
                end
            end
            SHIFT: begin
                if (time_q != last_q) begin
                    sr_d   = {8'd0, time_q};
                    last_d = time_q;
                    iter_d = 3'd0;
                end else begin
                    sr_d   = bcd_step(sr_q);
                    iter_d = iter_q + 3'd1;
                    if (iter_q == 3'd5) fsm_d = DONE;
                end
            end
            DONE: begin
                if (time_q != last_q) begin
                    fsm_d  = SHIFT;
                    sr_d   = {8'd0, time_q};
                    last_d = time_q;
                    iter_d = 3'd0;
                end else begin
                    tens_d = sr_q[13:10];
                    ones_d = sr_q[9:6];
                    fsm_d  = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase

        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            dsel_d     = ~dsel_q;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end

        lamp_red_d    = (state_q == 2'b00);
        lamp_green_d  = (state_q == 2'b10);
        lamp_yellow_d = (state_q == 2'b01);
`ifdef TRAFFIC_DISP_CHECK_EN
        if (fault_q) begin
            lamp_red_d    = 1'b0;
            lamp_green_d  = 1'b0;
            lamp_yellow_d = blink_q;
        end
`endif

        // Display is registered from next-state values so it tracks digits in the same edge they load.
        if (fault_nxt) begin
            an_d  = dsel_d ? 2'b01 : 2'b10;
            seg_d = SEG_DASH;
        end else if (!dsel_d) begin
            an_d  = 2'b10;
            seg_d = seg_enc(ones_d);
        end else if (tens_d == 4'd0) begin
            an_d  = 2'b11;
            seg_d = SEG_OFF;
        end else begin
            an_d  = 2'b01;
            seg_d = seg_enc(tens_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= 2'b00;
            time_q        <= 6'd0;
            fsm_q         <= IDLE;
            sr_q          <= 14'd0;
            iter_q        <= 3'd0;
            last_q        <= 6'd0;
            first_q       <= 1'b1;
            tens_q        <= 4'd0;
            ones_q        <= 4'd0;
            scan_cnt_q    <= '0;
            dsel_q        <= 1'b0;
            lamp_red_q    <= 1'b0;
            lamp_yellow_q <= 1'b0;
            lamp_green_q  <= 1'b0;
            seg_q         <= SEG_OFF;
            an_q          <= 2'b11;
        end else begin
            state_q       <= state_d;
            time_q        <= time_d;
            fsm_q         <= fsm_d;
            sr_q          <= sr_d;
            iter_q        <= iter_d;
            last_q        <= last_d;
            first_q       <= first_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            scan_cnt_q    <= scan_cnt_d;
            dsel_q        <= dsel_d;
            lamp_red_q    <= lamp_red_d;
            lamp_yellow_q <= lamp_yellow_d;
            lamp_green_q  <= lamp_green_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign lamp_red    = lamp_red_q;
    assign lamp_yellow = lamp_yellow_q;
    assign lamp_green  = lamp_green_q;
    assign seg         = seg_q;
    assign an          = an_q;
endmodule

// File: tb/tb_traffic_display_driver.sv
`timescale 1ns/1ps
// Bench for traffic_display_driver: vector table, corner-case sequences and a random stream
// checked every cycle against a sample-history model of lamps, digits, scan slot and fault.
module tb_traffic_display_driver;
    localparam int SCAN  = 4;
    localparam int BLINK = 8;
    localparam int HMAX  = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] state = 2'b00;
    logic [5:0] time_left = 6'd0;
    logic       lamp_red, lamp_yellow, lamp_green;
    logic [6:0] seg;
    logic [1:0] an;
    logic       fault;

    traffic_display_driver #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .time_left(time_left),
        .lamp_red(lamp_red), .lamp_yellow(lamp_yellow), .lamp_green(lamp_green),
        .seg(seg), .an(an), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic [5:0] tl;
        int         hold;
        logic [2:0] lamps;   // {red, yellow, green}
        int         tens;    // 15 = blanked
        int         ones;
    } vec_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         t;
    int         f_edge;
    int         disp;
    logic [1:0] cs[HMAX];
    logic [5:0] ct[HMAX];
    bit         fm[HMAX];
    logic [6:0] digit_code[10];
    vec_t       tbl[13];

    function automatic logic [1:0] next_phase(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b01;
            2'b01:   return 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int ctv(input int i);
        return (i < 0) ? 0 : int'(ct[i]);
    endfunction

    function automatic logic [12:0] model_out();
        logic r, y, g;
        logic [1:0] a;
        logic [6:0] s;
        int dsel;
        if (fm[t-1]) begin
            r = 1'b0; g = 1'b0;
            y = (((t - f_edge - 1) / BLINK) % 2) == 0;
        end else begin
            r = (cs[t-1] == 2'b00);
            g = (cs[t-1] == 2'b10);
            y = (cs[t-1] == 2'b01);
        end
        dsel = (t / SCAN) % 2;
        if (fm[t]) begin
            a = (dsel == 1) ? 2'b01 : 2'b10;
            s = 7'b0111111;
        end else if (dsel == 0) begin
            a = 2'b10; s = digit_code[disp % 10];
        end else if (disp / 10 == 0) begin
            a = 2'b11; s = 7'h7F;
        end else begin
            a = 2'b01; s = digit_code[disp / 10];
        end
        return {r, y, g, fm[t], a, s};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d: got %0h, want %0h", name, t, act, exp);
        end
    endtask

    task automatic tick();
        bit viol;
        bit stable;
        @(posedge clk);
        t++;
        if (t >= HMAX) begin
            $display("FAIL history t=%0d: got overflow, want < %0d", t, HMAX);
            $fatal(1, "history overflow");
        end
        cs[t] = state;
        ct[t] = time_left;
        viol = 1'b0;
`ifdef TRAFFIC_DISP_CHECK_EN
        if (cs[t-1] == 2'b11) viol = 1'b1;
        if (t >= 3) begin
            if (cs[t-1] != cs[t-2]) begin
                if (cs[t-1] != next_phase(cs[t-2])) viol = 1'b1;
            end else if (ct[t-2] != 0 && int'(ct[t-1]) != int'(ct[t-2]) &&
                         int'(ct[t-1]) != int'(ct[t-2]) - 1) begin
                viol = 1'b1;
            end
        end
`endif
        fm[t] = fm[t-1] | viol;
        if (fm[t] && !fm[t-1]) f_edge = t;
        // A value reaches the digits once it has been captured unchanged for eight edges.
        stable = 1'b1;
        for (int k = t - 7; k <= t - 1; k++) if (ctv(k) != ctv(t - 8)) stable = 1'b0;
        if (stable) disp = ctv(t - 8);
        #1;
        check("tick", {19'd0, lamp_red, lamp_yellow, lamp_green, fault, an, seg}, {19'd0, model_out()});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset", {lamp_red, lamp_yellow, lamp_green, fault, an, seg},
              {3'b000, 1'b0, 2'b11, 7'h7F});
        t = 0; cs[0] = 2'b00; ct[0] = 6'd0; fm[0] = 1'b0; disp = 0; f_edge = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic observe(output logic [6:0] ones_s, output logic [6:0] tens_s);
        ones_s = 7'bx;
        tens_s = 7'bx;
        repeat (2 * SCAN) begin
            tick();
            if (an == 2'b10) ones_s = seg;
            else if (an == 2'b01) tens_s = seg;
            else if (an == 2'b11) tens_s = 7'h7F;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [6:0] o_s, t_s;
        state = v.st;
        time_left = v.tl;
        repeat (v.hold) tick();
        observe(o_s, t_s);
        check("lamps", {29'd0, lamp_red, lamp_yellow, lamp_green}, {29'd0, v.lamps});
        check("ones", {25'd0, o_s}, {25'd0, digit_code[v.ones]});
        check("tens", {25'd0, t_s}, {25'd0, (v.tens == 15) ? 7'h7F : digit_code[v.tens]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout t=%0d: got no finish, want finish", t);
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int r;
        logic [6:0] o_s, t_s;
        digit_code = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                       7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        tbl[0]  = '{2'b00, 6'd0,  10, 3'b100, 15, 0};
        tbl[1]  = '{2'b10, 6'd0,  10, 3'b001, 15, 0};
        tbl[2]  = '{2'b10, 6'd45, 10, 3'b001, 4,  5};
        tbl[3]  = '{2'b10, 6'd44, 10, 3'b001, 4,  4};
        tbl[4]  = '{2'b01, 6'd3,  10, 3'b010, 15, 3};
        tbl[5]  = '{2'b01, 6'd2,  10, 3'b010, 15, 2};
        tbl[6]  = '{2'b00, 6'd60, 10, 3'b100, 6,  0};
        tbl[7]  = '{2'b00, 6'd59, 10, 3'b100, 5,  9};
        tbl[8]  = '{2'b10, 6'd9,  10, 3'b001, 15, 9};
        tbl[9]  = '{2'b10, 6'd8,  10, 3'b001, 15, 8};
        tbl[10] = '{2'b01, 6'd0,  10, 3'b010, 15, 0};
        tbl[11] = '{2'b00, 6'd10, 10, 3'b100, 1,  0};
        tbl[12] = '{2'b10, 6'd63, 10, 3'b001, 6,  3};

        do_reset();
        for (int i = 0; i < 13; i++) run_vec(tbl[i]);

        // Countdown from 60 with latency and leading-zero checks.
        state = 2'b01; time_left = 6'd5;
        repeat (10) tick();
        state = 2'b00; time_left = 6'd60;
        tick();
        repeat (7) tick();
        tick();
        check("latency_60", {23'd0, an, seg},
              {23'd0, ((t / SCAN) % 2 == 1) ? {2'b01, digit_code[6]} : {2'b10, digit_code[0]}});
        for (int v = 59; v >= 9; v--) begin
            time_left = 6'(v);
            tick();
        end
        repeat (9) tick();
        for (int k = 0; k < SCAN && (t / SCAN) % 2 == 0; k++) tick();
        check("tens_blank_9", {30'd0, an}, {30'd0, 2'b11});
        for (int v = 8; v >= 0; v--) begin
            time_left = 6'(v);
            tick();
        end
        repeat (10) tick();
        check("red_countdown", {29'd0, lamp_red, lamp_yellow, lamp_green}, {29'd0, 3'b100});

        // Value changes one cycle after a conversion starts: the old target must never show.
        do_reset();
        state = 2'b00; time_left = 6'd7;
        repeat (12) tick();
        state = 2'b10; time_left = 6'd45;
        repeat (2) tick();
        state = 2'b01; time_left = 6'd30;
        bad = 0;
        repeat (20) begin
            tick();
            if (an != 2'b11 && (seg == digit_code[4] || seg == digit_code[5])) bad++;
        end
        check("no_stale_45", bad, 0);
        observe(o_s, t_s);
        check("restart_ones", {25'd0, o_s}, {25'd0, digit_code[0]});
        check("restart_tens", {25'd0, t_s}, {25'd0, digit_code[3]});

`ifdef TRAFFIC_DISP_CHECK_EN
        do_reset();
        state = 2'b00; time_left = 6'd5;
        repeat (6) tick();
        state = 2'b01;
        tick();
        check("fault_pre", {31'd0, fault}, 32'd0);
        tick();
        check("fault_rise", {31'd0, fault}, 32'd1);
        tick();
        check("fault_lamps", {29'd0, lamp_red, lamp_yellow, lamp_green}, {29'd0, 3'b010});
        repeat (7) tick();
        check("yellow_on_end", {31'd0, lamp_yellow}, 32'd1);
        tick();
        check("yellow_off", {31'd0, lamp_yellow}, 32'd0);
        observe(o_s, t_s);
        check("dash_ones", {25'd0, o_s}, {25'd0, 7'b0111111});
        check("dash_tens", {25'd0, t_s}, {25'd0, 7'b0111111});
        state = 2'b00; time_left = 6'd5;
        repeat (10) tick();
        check("fault_sticky", {31'd0, fault}, 32'd1);
        do_reset();
        tick();
        check("fault_cleared", {31'd0, fault}, 32'd0);
`else
        do_reset();
        run_vec('{2'b11, 6'd23, 10, 3'b000, 2, 3});
        check("no_fault_11", {31'd0, fault}, 32'd0);
        run_vec('{2'b11, 6'd40, 10, 3'b000, 4, 0});
`endif

        // Random mostly-legal streams with occasional arbitrary codes.
        for (int round = 0; round < 4; round++) begin
            do_reset();
            state = 2'b00; time_left = 6'($urandom_range(0, 63));
            for (int n = 0; n < 300; n++) begin
                r = $urandom_range(0, 99);
                if (r < 50) begin
                end else if (r < 80) begin
                    if (time_left != 6'd0) time_left = time_left - 6'd1;
                    else time_left = 6'($urandom_range(0, 63));
                end else if (r < 97) begin
                    state = next_phase(state);
                    time_left = 6'($urandom_range(0, 63));
                end else begin
                    state = 2'($urandom_range(0, 3));
                    time_left = 6'($urandom_range(0, 63));
                end
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
